cascade_sequencer: RTL and testbench

CASCADE_SEQUENCER -- requirements
Module: cascade_sequencer

---
 rtl/cascade_sequencer_pkg.sv | 26 ++
 rtl/cascade_sequencer_prio_enc.sv | 30 +++
 rtl/cascade_sequencer.sv | 153 +++++++++++++++
 tb/tb_cascade_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cascade_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cascade_sequencer_pkg
// Description : Shared FSM states, data-byte codes and default ID width for
//               the INTA cascade sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cascade_sequencer_pkg;

    localparam int DEFAULT_ID_W = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        GAP1 = 3'd2,
        P2   = 3'd3,
        GAP2 = 3'd4,
        P3   = 3'd5
    } state_t;

    localparam logic [1:0] BYTE_CALL = 2'd0;
    localparam logic [1:0] BYTE_LO   = 2'd1;
    localparam logic [1:0] BYTE_HI   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cascade_sequencer_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc
// Description : Lowest-set-bit priority encoder; o_any flags a non-empty
//               request vector.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc #(
    parameter  int N_IR  = 8,
    localparam int IDX_W = (N_IR > 1) ? $clog2(N_IR) : 1
) (
    input  logic [N_IR-1:0]  i_req,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    // Scanning downward lets the lowest set bit be the last (winning) write.
    always_comb begin
        o_idx = '0;
        for (int i = N_IR - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/cascade_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cascade_sequencer
// Description : 8259-style INTA cycle sequencer: tracks acknowledge pulses,
//               drives the CAS bus as master and selects the data byte owner.
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_sequencer
    import cascade_sequencer_pkg::*;
#(
    parameter  int ID_W = DEFAULT_ID_W,
    localparam int N_IR = 2**ID_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inta_n,
    input  logic            mode_8086,
    input  logic            sngl,
    input  logic            buffered,
    input  logic            buf_ms,
    input  logic            sp_n,
    input  logic [N_IR-1:0] icw3,
    input  logic [N_IR-1:0] isr_sel,
    input  logic [ID_W-1:0] cas_in,
    output logic [ID_W-1:0] cas_out,
    output logic            cas_oe,
    output logic            en_n,
    output logic            send_vector,
    output logic [1:0]      byte_sel,
    output logic            cycle_done
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_inta_q;
    logic              r_mode_8086;
    logic              r_hit;
    logic [ID_W-1:0]   r_idx;
    logic              r_sel;
    logic              r_send_vector;
    logic [1:0]        r_byte_sel;
    logic              r_cycle_done;

    logic              w_fall;
    logic              w_rise;
    logic              w_start;
    logic              w_is_master;
    logic              w_owner;
    logic              w_mode_8086;
    logic              w_hit;
    logic [ID_W-1:0]   w_idx;
    logic              w_cas_active;
    logic              w_send_next;
    logic [1:0]        w_byte_next;

    prio_enc #(
        .N_IR (N_IR)
    ) u_prio_enc (
        .i_req (isr_sel & icw3),
        .o_any (w_hit),
        .o_idx (w_idx)
    );

    assign w_fall      = r_inta_q & ~inta_n;
    assign w_rise      = ~r_inta_q & inta_n;
    assign w_start     = (r_state == IDLE) && w_fall;
    assign w_is_master = sngl | (buffered ? buf_ms : sp_n);
    assign w_owner     = w_is_master ? (sngl | ~r_hit) : r_sel;
    // The first pulse is decoded before the mode latch has loaded.
    assign w_mode_8086 = w_start ? mode_8086 : r_mode_8086;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_send_next  = 1'b0;
        w_byte_next  = BYTE_CALL;
        case (r_state)
            IDLE:    if (w_fall) w_state_next = P1;
            P1:      if (w_rise) w_state_next = GAP1;
            GAP1:    if (w_fall) w_state_next = P2;
            P2:      if (w_rise) w_state_next = r_mode_8086 ? IDLE : GAP2;
            GAP2:    if (w_fall) w_state_next = P3;
            P3:      if (w_rise) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // Outputs follow the state being entered so they register with it.
        case (w_state_next)
            P1: begin
                if (!w_mode_8086 && w_is_master) begin
                    w_send_next = 1'b1;
                    w_byte_next = BYTE_CALL;
                end
            end
            P2: begin
                if (w_owner) begin
                    w_send_next = 1'b1;
                    w_byte_next = BYTE_LO;
                end
            end
            P3: begin
                if (w_owner) begin
                    w_send_next = 1'b1;
                    w_byte_next = BYTE_HI;
                end
            end
            default: begin
                w_send_next = 1'b0;
                w_byte_next = BYTE_CALL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inta_q      <= 1'b1;
            r_mode_8086   <= 1'b0;
            r_hit         <= 1'b0;
            r_idx         <= '0;
            r_sel         <= 1'b0;
            r_send_vector <= 1'b0;
            r_byte_sel    <= BYTE_CALL;
            r_cycle_done  <= 1'b0;
        end else begin
            r_inta_q <= inta_n;
            if (w_start) begin
                r_mode_8086 <= mode_8086;
                r_hit       <= w_hit;
                r_idx       <= w_idx;
                r_sel       <= (cas_in == icw3[ID_W-1:0]);
            end
            r_send_vector <= w_send_next;
            r_byte_sel    <= w_byte_next;
            r_cycle_done  <= (r_state != IDLE) && (w_state_next == IDLE);
        end
    end

    assign w_cas_active = (r_state != IDLE) && w_is_master && !sngl && r_hit;
    assign cas_oe       = w_cas_active;
    assign cas_out      = w_cas_active ? r_idx : '0;
    assign send_vector  = r_send_vector;
    assign byte_sel     = r_byte_sel;
    assign en_n         = buffered ? ~r_send_vector : 1'b1;
    assign cycle_done   = r_cycle_done;

endmodule
`default_nettype wire

// File: tb/tb_cascade_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cascade_sequencer
// Description : Self-checking bench; pulse-counting reference model compared
//               against the sequencer every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cascade_sequencer;

    localparam int ID_W = 3;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, inta_n, mode_8086, sngl, buffered, buf_ms, sp_n;
    logic [7:0] icw3, isr_sel;
    logic [2:0] cas_in;
    logic [2:0] cas_out;
    logic       cas_oe, en_n, send_vector, cycle_done;
    logic [1:0] byte_sel;
    logic [1:0] cas_out_b, byte_sel_b;
    logic       cas_oe_b, en_n_b, send_vector_b, cycle_done_b;

    cascade_sequencer #(.ID_W(ID_W)) dut (
        .clk (clk), .reset (reset), .inta_n (inta_n), .mode_8086 (mode_8086),
        .sngl (sngl), .buffered (buffered), .buf_ms (buf_ms), .sp_n (sp_n),
        .icw3 (icw3), .isr_sel (isr_sel), .cas_in (cas_in),
        .cas_out (cas_out), .cas_oe (cas_oe), .en_n (en_n),
        .send_vector (send_vector), .byte_sel (byte_sel), .cycle_done (cycle_done)
    );

    cascade_sequencer #(.ID_W(2)) dut_b (
        .clk (clk), .reset (reset), .inta_n (inta_n), .mode_8086 (mode_8086),
        .sngl (sngl), .buffered (buffered), .buf_ms (buf_ms), .sp_n (sp_n),
        .icw3 (icw3[3:0]), .isr_sel (isr_sel[3:0]), .cas_in (cas_in[1:0]),
        .cas_out (cas_out_b), .cas_oe (cas_oe_b), .en_n (en_n_b),
        .send_vector (send_vector_b), .byte_sel (byte_sel_b), .cycle_done (cycle_done_b)
    );

    int n_checks;
    int n_fail;
    int n_done_seen;
    int d0;

    // Reference model: which acknowledge pulse we are in and what was latched.
    int m_pulse;
    bit m_q, m_low, m_done, m_mode, m_hit, m_sel;
    int m_idx;

    function automatic int lowest_idx(input int v);
        int lb;
        lb = v & (-v);
        return $clog2(lb);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int masked;
        if (reset) begin
            m_q = 1'b1; m_pulse = 0; m_low = 1'b0; m_done = 1'b0;
            m_mode = 1'b0; m_hit = 1'b0; m_sel = 1'b0; m_idx = 0;
        end else begin
            m_done = 1'b0;
            if (m_q && !inta_n) begin
                if (m_pulse == 0) begin
                    masked = int'(isr_sel & icw3);
                    m_mode = mode_8086;
                    m_hit  = (masked != 0);
                    m_idx  = lowest_idx(masked);
                    m_sel  = (cas_in == icw3[2:0]);
                end
                m_pulse++;
                m_low = 1'b1;
            end else if (!m_q && inta_n && m_pulse != 0) begin
                m_low = 1'b0;
                if (m_pulse == (m_mode ? 2 : 3)) begin
                    m_pulse = 0;
                    m_done  = 1'b1;
                end
            end
            m_q = inta_n;
        end
    endtask

    task automatic check_all();
        bit master, owner, e_send, e_oe;
        int e_byte, e_out;
        master = (sngl | (buffered ? buf_ms : sp_n)) === 1'b1;
        owner  = master ? (sngl === 1'b1 || !m_hit) : m_sel;
        e_send = m_low && ((m_pulse == 1 && !m_mode && master) || (m_pulse >= 2 && owner));
        e_byte = e_send ? m_pulse - 1 : 0;
        e_oe   = (m_pulse != 0) && master && (sngl === 1'b0) && m_hit;
        e_out  = e_oe ? m_idx : 0;
        check("send_vector", {7'd0, send_vector}, {7'd0, e_send});
        check("byte_sel", {6'd0, byte_sel}, 8'(e_byte));
        check("cas_oe", {7'd0, cas_oe}, {7'd0, e_oe});
        check("cas_out", {5'd0, cas_out}, 8'(e_out));
        check("en_n", {7'd0, en_n}, {7'd0, (buffered === 1'b1) ? !e_send : 1'b1});
        check("cycle_done", {7'd0, cycle_done}, {7'd0, m_done});
        if (cycle_done === 1'b1) n_done_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_cycle(input bit scramble);
        int np;
        np = mode_8086 ? 2 : 3;
        for (int p = 1; p <= np; p++) begin
            inta_n = 1'b0;
            tick();
            if (scramble && p == 1) begin
                isr_sel   = 8'($urandom);
                icw3      = 8'($urandom);
                cas_in    = 3'($urandom);
                mode_8086 = 1'($urandom);
            end
            repeat ($urandom_range(3, 0)) tick();
            inta_n = 1'b1;
            repeat ($urandom_range(3, 1)) tick();
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_done_seen = 0; d0 = 0;
        m_q = 1'b1; m_pulse = 0; m_low = 1'b0; m_done = 1'b0;
        m_mode = 1'b0; m_hit = 1'b0; m_sel = 1'b0; m_idx = 0;
        reset = 1'b1; inta_n = 1'b1; mode_8086 = 1'b1; sngl = 1'b0;
        buffered = 1'b0; buf_ms = 1'b0; sp_n = 1'b1;
        icw3 = 8'h00; isr_sel = 8'h00; cas_in = 3'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Master, 8086, slave hit on IR2: CAS=2, no local drive, one done
        icw3 = 8'h04; isr_sel = 8'h04; mode_8086 = 1'b1; n_done_seen = 0;
        run_cycle(1'b0);
        tick();
        check("t1_done_count", 8'(n_done_seen), 8'd1);

        // Master, 8086, no slave hit: master supplies the vector
        isr_sel = 8'h10;
        run_cycle(1'b0);

        // Slave, 8080, matching and non-matching ID
        sp_n = 1'b0; icw3 = 8'h05; cas_in = 3'd5; mode_8086 = 1'b0;
        run_cycle(1'b0);
        cas_in = 3'd3;
        run_cycle(1'b0);

        // Buffered master, 8080, all three bytes
        buffered = 1'b1; buf_ms = 1'b1; icw3 = 8'h00; isr_sel = 8'hA5;
        run_cycle(1'b0);

        // Single mode forces master with the CAS bus idle
        buffered = 1'b0; sngl = 1'b1; icw3 = 8'hFF; isr_sel = 8'h01;
        run_cycle(1'b0);

        // Narrow instance: idx of 0x6 & 0xF is 1; reset aborts inside GAP1
        sngl = 1'b0; sp_n = 1'b1; mode_8086 = 1'b1; icw3 = 8'h0F; isr_sel = 8'h06;
        d0 = n_done_seen;
        inta_n = 1'b0;
        tick();
        tick();
        check("idw2_cas_out", {6'd0, cas_out_b}, 8'd1);
        check("idw2_cas_oe", {7'd0, cas_oe_b}, 8'd1);
        inta_n = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idw2_rst_cas_oe", {7'd0, cas_oe_b}, 8'd0);
        check("idw2_rst_cas_out", {6'd0, cas_out_b}, 8'd0);
        check("idw2_rst_send", {7'd0, send_vector_b}, 8'd0);
        check("idw2_rst_byte", {6'd0, byte_sel_b}, 8'd0);
        check("idw2_rst_en_n", {7'd0, en_n_b}, 8'd1);
        check("idw2_rst_done", {7'd0, cycle_done_b}, 8'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("abort_no_done", 8'(n_done_seen), 8'(d0));

        // Randomised configurations with mid-cycle input scrambling
        repeat (40) begin
            sngl      = ($urandom_range(3, 0) == 0);
            buffered  = 1'($urandom);
            buf_ms    = 1'($urandom);
            sp_n      = 1'($urandom);
            mode_8086 = 1'($urandom);
            icw3      = 8'($urandom);
            isr_sel   = 8'($urandom);
            cas_in    = 3'($urandom);
            run_cycle(1'b1);
            repeat ($urandom_range(2, 0)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
